key_schedule_ctrl: RTL and testbench
====================================

KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 SHALL have no parameters; AES-128 only, 11 round keys of 128 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 start  input  1  request to expand key_in; sampled only in IDLE.
REQ-005 key_in  input  [128:1]  cipher key; word0 = key_in[128:97], word3 = key_in[32:1].
REQ-006 rk_valid  output  1  rk_out/rk_round hold a valid round key.
REQ-007 rk_ready  input  1  consumer accepts the round key when rk_valid=1 and rk_ready=1.
REQ-008 rk_out  output  [128:1]  current round key, same word order as key_in.
REQ-009 rk_round  output  [4:1]  index of rk_out, 0..10.
REQ-010 busy  output  1  high from start acceptance until the round-10 handshake.
REQ-011 done  output  1  single-cycle pulse in the cycle after the round-10 handshake.
REQ-012 rd_round  input  [4:1]  stored-key read index; present only with KEY_STORE_EN.
REQ-013 rd_key  output  [128:1]  stored round key; present only with KEY_STORE_EN.

Function
REQ-014 SHALL implement FSM IDLE, EXPAND, DONE.
REQ-015 IDLE and start=1: capture key_in; next cycle EXPAND with rk_round=0, rk_out=key_in, rk_valid=1.
REQ-016 EXPAND, handshake with rk_round<10: next cycle rk_round+1, rk_out = next round key; rk_valid stays 1.
REQ-017 Next key: w4 = w0 ^ SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w5 = w1^w4; w6 = w2^w5; w7 = w3^w6.
REQ-018 Rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36; the S-box is the FIPS-197 S-box.
REQ-019 rk_valid=1 and rk_ready=0: rk_out and rk_round hold unchanged; the FSM stalls with no limit.
REQ-020 Handshake with rk_round=10: next cycle DONE, rk_valid=0, busy=0, done=1.
REQ-021 DONE: return to IDLE after one cycle; done is high only in DONE.
REQ-022 start while busy=1 or in DONE: ignore it; key_in changes after capture have no effect.
REQ-023 start in the same cycle as the DONE->IDLE transition: ignore it; start is sampled only when the state is IDLE.
REQ-024 Throughput: with rk_ready held 1, all 11 keys transfer on 11 consecutive cycles; start to done is 12 cycles.
REQ-025 The next-key path SHALL be registered; the combinational path per cycle is one g-function plus XOR chain.

Reset
REQ-026 rst=1 at a clock edge: state=IDLE, rk_valid=0, busy=0, done=0, rk_round=0, rk_out=0.
REQ-027 rst during EXPAND SHALL abort the expansion; no done pulse follows; the next start begins at round 0.
REQ-028 rst has priority over start and over the handshake in the same cycle.
REQ-029 With KEY_STORE_EN, reset SHALL clear the valid flags only; the key storage contents need not reset.

Configuration
REQ-030 Macro KEY_STORE_EN defined: 11x128 storage; each key is written when it is presented (rk_valid rising or after an advance).
REQ-031 With KEY_STORE_EN, rd_key = store[rd_round] combinationally; rd_round > 10 returns 0; a slot not yet written since reset or start returns 0.
REQ-032 Macro KEY_STORE_EN undefined: rd_round and rd_key are absent; streaming behaviour is identical.

Verification
REQ-033 rst, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1 -> round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done 12 cycles after start.
REQ-034 Same key, rk_ready=0 for 5 cycles at round 3 -> rk_out/rk_round held constant; the sequence resumes with no key skipped or duplicated.
REQ-035 Second start pulse with a different key at round 5 -> ignored; the original sequence completes unchanged.
REQ-036 rst asserted at round 6 -> next cycle rk_valid=0, busy=0, no done pulse; a fresh start reproduces round 0 = key_in.
REQ-037 KEY_STORE_EN, after REQ-033 -> rd_round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round=12 gives 0.
REQ-038 Back-to-back starts (start high continuously) -> a new expansion begins on the first IDLE cycle after DONE, i.e. a 13-cycle period.

Source files
------------

// File: rtl/key_schedule_ctrl_if.sv
// Round-key streaming bundle for key_schedule_ctrl: start/key request in, round keys out.
// Handshake: a round key moves when rk_valid and rk_ready are both 1 at a rising clk edge; while rk_valid is 1, rk_out/rk_round stay stable until that edge.
interface key_schedule_ctrl_if;
    logic         start;
    logic [128:1] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [128:1] rk_out;
    logic [4:1]   rk_round;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, rk_out, rk_round, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, rk_out, rk_round, busy, done
    );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion streamed one round key per handshake (rounds 0..10).
// Optional macro KEY_STORE_EN adds an 11-entry round-key store with a combinational read port.
module key_schedule_ctrl (
    input  logic                clk,
    input  logic                rst,
    key_schedule_ctrl_if.slave  ks,
    output logic [1:0]          dbg_state
`ifdef KEY_STORE_EN
    ,
    input  logic [4:1]          rd_round,
    output logic [128:1]        rd_key
`endif
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       state;
    logic         advance;
    logic [31:0]  w0, w1, w2, w3, rot, sub, w4, w5, w6, w7;
    logic [7:0]   rcon;
    logic [128:1] next_key;
    logic [3:0]   next_idx;

    assign advance   = ks.rk_valid && ks.rk_ready;
    assign dbg_state = state;
    assign next_idx  = ks.rk_round + 4'd1;

    // One g-function plus the XOR chain, fed straight from the registered current key.
    assign w0  = ks.rk_out[128:97];
    assign w1  = ks.rk_out[96:65];
    assign w2  = ks.rk_out[64:33];
    assign w3  = ks.rk_out[32:1];
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    assign w4  = w0 ^ sub ^ {rcon, 24'h0};
    assign w5  = w1 ^ w4;
    assign w6  = w2 ^ w5;
    assign w7  = w3 ^ w6;
    assign next_key = {w4, w5, w6, w7};

    // Rcon indexed by the round being produced, i.e. current round + 1.
    always_comb begin
        rcon = 8'h00;
        case (ks.rk_round)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ks.rk_valid <= 1'b0;
            ks.busy     <= 1'b0;
            ks.done     <= 1'b0;
            ks.rk_round <= 4'd0;
            ks.rk_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ks.done <= 1'b0;
                    if (ks.start) begin
                        ks.rk_out   <= ks.key_in;
                        ks.rk_round <= 4'd0;
                        ks.rk_valid <= 1'b1;
                        ks.busy     <= 1'b1;
                        state       <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (advance) begin
                        if (ks.rk_round == 4'd10) begin
                            ks.rk_valid <= 1'b0;
                            ks.busy     <= 1'b0;
                            ks.done     <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            ks.rk_round <= next_idx;
                            ks.rk_out   <= next_key;
                        end
                    end
                end
                S_DONE: begin
                    ks.done <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef KEY_STORE_EN
    logic [128:1] store [0:10];
    logic [10:0]  slot_valid;

    // Only the valid flags reset; data slots are written alongside rk_out loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= '0;
        end else if (state == S_IDLE && ks.start) begin
            slot_valid <= 11'd1;
        end else if (state == S_EXPAND && advance && ks.rk_round != 4'd10) begin
            slot_valid[next_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && ks.start) begin
            store[0] <= ks.key_in;
        end else if (state == S_EXPAND && advance && ks.rk_round != 4'd10) begin
            store[next_idx] <= next_key;
        end
    end

    always_comb begin
        rd_key = '0;
        if (rd_round <= 4'd10 && slot_valid[rd_round]) begin
            rd_key = store[rd_round];
        end
    end
`endif
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: FIPS-197 round-key table, scoreboard on the rk handshake, timing corners.
module tb_key_schedule_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_schedule_ctrl_if ks();
    logic [1:0] dbg_state;
`ifdef KEY_STORE_EN
    logic [4:1]   rd_round;
    logic [128:1] rd_key;
`endif

    key_schedule_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ks        (ks),
        .dbg_state (dbg_state)
`ifdef KEY_STORE_EN
        ,
        .rd_round  (rd_round),
        .rd_key    (rd_key)
`endif
    );

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
    } vec_t;

    vec_t         vecs [11];
    logic [131:0] exp_q [$];
    logic [131:0] sb_e;
    int           errors = 0;
    int           checks = 0;
    int           cyc;
    int           done_cnt;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake must match the next expected {round, key}.
    always @(negedge clk) begin
        if (rst === 1'b0 && ks.rk_valid === 1'b1 && ks.rk_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got round %0d key %h, expected no transfer", ks.rk_round, ks.rk_out);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_round_key", {ks.rk_round, ks.rk_out}, sb_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all();
        for (int i = 0; i < 11; i++) exp_q.push_back({vecs[i].round, vecs[i].key});
    endtask

    task automatic start_pulse(input logic [127:0] key);
        ks.key_in = key;
        ks.start  = 1'b1;
        tick();
        ks.start  = 1'b0;
        ks.key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_round(input string name, input logic [3:0] r);
        int n = 0;
        while (!(ks.rk_valid && ks.rk_round == r) && n < 50) begin
            tick();
            n++;
        end
        check(name, (n < 50), 1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!ks.done && n < budget) begin
            tick();
            n++;
        end
        check(name, ks.done, 1);
    endtask

    initial begin
        vecs[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        vecs[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        vecs[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        vecs[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        vecs[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        vecs[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        rst         = 1'b1;
        ks.start    = 1'b1;
        ks.key_in   = vecs[0].key;
        ks.rk_ready = 1'b1;
`ifdef KEY_STORE_EN
        rd_round    = 4'd0;
`endif
        tick();
        check("rst_valid", ks.rk_valid, 0);
        check("rst_busy",  ks.busy, 0);
        check("rst_done",  ks.done, 0);
        check("rst_round", ks.rk_round, 0);
        check("rst_key",   ks.rk_out, 0);
        check("rst_state", dbg_state, 0);
        ks.start = 1'b0;
        rst      = 1'b0;
        tick();

        // Full expansion at full throughput.
        push_all();
        start_pulse(vecs[0].key);
        check("a_busy", ks.busy, 1);
        check("a_round0", {ks.rk_round, ks.rk_out}, {vecs[0].round, vecs[0].key});
        cyc = 1;
        while (!ks.done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("a_start_to_done", cyc, 12);
        check("a_busy_at_done", ks.busy, 0);
        check("a_valid_at_done", ks.rk_valid, 0);
        tick();
        check("a_done_pulse", ks.done, 0);
        check("a_queue_empty", exp_q.size(), 0);
`ifdef KEY_STORE_EN
        rd_round = 4'd10;
        #1;
        check("a_store_r10", rd_key, vecs[10].key);
        rd_round = 4'd12;
        #1;
        check("a_store_r12", rd_key, 0);
        rd_round = 4'd3;
        #1;
        check("a_store_r3", rd_key, vecs[3].key);
`endif

        // Backpressure for 5 cycles at round 3.
        push_all();
        start_pulse(vecs[0].key);
        wait_round("b_reach_r3", 4'd3);
        ks.rk_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b_hold_round", ks.rk_round, 3);
            check("b_hold_key", ks.rk_out, vecs[3].key);
        end
        ks.rk_ready = 1'b1;
        wait_done("b_done", 40);
        tick();
        check("b_queue_empty", exp_q.size(), 0);

        // A second start mid-expansion must be ignored.
        push_all();
        start_pulse(vecs[0].key);
        wait_round("c_reach_r5", 4'd5);
        start_pulse(128'h000102030405060708090a0b0c0d0e0f);
        wait_done("c_done", 40);
        tick();
        check("c_queue_empty", exp_q.size(), 0);

        // Reset aborts at round 6, then a clean restart.
        push_all();
        start_pulse(vecs[0].key);
        wait_round("d_reach_r6", 4'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("d_valid_after_rst", ks.rk_valid, 0);
        check("d_busy_after_rst", ks.busy, 0);
        check("d_state_after_rst", dbg_state, 0);
        exp_q.delete();
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ks.done) done_cnt++;
        end
        check("d_no_done", done_cnt, 0);
        push_all();
        start_pulse(vecs[0].key);
        check("d_restart_round0", {ks.rk_round, ks.rk_out}, {vecs[0].round, vecs[0].key});
        wait_done("d_done", 40);
        tick();
        check("d_queue_empty", exp_q.size(), 0);

        // Random backpressure.
        push_all();
        start_pulse(vecs[0].key);
        cyc = 0;
        while (!ks.done && cyc < 300) begin
            ks.rk_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        check("f_done", ks.done, 1);
        ks.rk_ready = 1'b1;
        tick();
        check("f_queue_empty", exp_q.size(), 0);

        // start held high: expansions repeat with a 13-cycle period.
        push_all();
        push_all();
        ks.key_in = vecs[0].key;
        ks.start  = 1'b1;
        tick();
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(ks.rk_valid && ks.rk_round == 4'd0) && cyc < 40);
        check("e_period", cyc, 13);
        ks.start = 1'b0;
        wait_done("e_done", 40);
        tick();
        check("e_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
